// File: rtl/bp_param.sv
// bp_param: multicycle 4-register processor with req/ack data memory.
// Define BP_CARRY_EN to add the carry flag and the BC (branch-on-carry) instruction.
module bp_param #(
  parameter int DW = 16,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   i_data,
  output logic [AW-1:0] i_addr,
  input  logic [DW-1:0] dm_data_r,
  input  logic          dm_ack,
  output logic          dm_req,
  output logic          dm_we,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_data_w,
  output logic          halted
);
  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;
  state_t state, state_n;
  logic [15:0] ir;
  logic [AW-1:0] pc;
  logic [DW-1:0] rf [4];
  logic [3:0] op;
  logic [1:0] rd, rs;
  logic [DW-1:0] a, b, sum, dif, alu, imm_d;
  logic [AW-1:0] imm_a;
  logic is_mem, wr_alu, take;
  assign op = ir[15:12];
  assign rd = ir[11:10];
  assign rs = ir[9:8];
  assign imm_d = DW'(ir[7:0]);
  assign imm_a = AW'(ir[7:0]);
  assign a = rf[rd];
  assign b = rf[rs];
  assign sum = a + b;
  assign dif = a - b;
  assign is_mem = op == 4'h7 || op == 4'h8;
  assign wr_alu = op >= 4'h1 && op <= 4'h6;
  assign alu = op == 4'h1 ? imm_d :
               op == 4'h2 ? sum :
               op == 4'h3 ? dif :
               op == 4'h4 ? a & b :
               op == 4'h5 ? a | b : a ^ b;
  assign i_addr = pc;
  assign halted = state == HALT;
`ifdef BP_CARRY_EN
  logic carry;
  assign take = op == 4'h9 || (op == 4'hA && a == '0) || (op == 4'hC && carry);
  // sum < a exposes the carry-out without widening the adder
  always_ff @(posedge clk or posedge rst)
    if (rst) carry <= 1'b0;
    else if (state == EXEC) carry <= op == 4'h2 ? sum < a : op == 4'h3 ? a < b : carry;
`else
  assign take = op == 4'h9 || (op == 4'hA && a == '0);
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= FETCH;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (state == FETCH) state_n = EXEC;
    else if (state == EXEC) state_n = is_mem ? MEM : op == 4'hB ? HALT : FETCH;
    else if (state == MEM && dm_ack) state_n = FETCH;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ir <= '0;
      pc <= '0;
      rf <= '{default: '0};
      dm_req <= 1'b0;
      dm_we <= 1'b0;
      dm_addr <= '0;
      dm_data_w <= '0;
    end else if (state == FETCH) begin
      ir <= i_data;
      pc <= pc + 1'b1;
    end else if (state == EXEC) begin
      if (take) pc <= imm_a;
      if (wr_alu) rf[rd] <= alu;
      if (is_mem) begin
        dm_req <= 1'b1;
        dm_we <= op == 4'h8;
        dm_addr <= imm_a;
        dm_data_w <= a;
      end
    end else if (state == MEM && dm_ack) begin
      dm_req <= 1'b0;
      if (!dm_we) rf[rd] <= dm_data_r;
    end
endmodule
